// File: rtl/wb_spec_arbiter.sv
// wb_spec_arbiter: merges NSRC completion streams into one register-file
// write port. Each source owns a DEPTH-entry FIFO whose entries carry a
// speculative tag; speculative entries wait for branch resolution and are
// then committed (tag cleared) or squashed (tail rolled back).
// Lower source index has higher priority. An empty FIFO may pass a
// non-speculative input straight through to the output register.

module wb_spec_arbiter #(
    parameter int NSRC  = 3,
    parameter int DEPTH = 8,
    parameter int DW    = 32,
    parameter int RW    = 5
) (
    input  logic                                     CLK,
    input  logic                                     nRST,
    input  logic [NSRC-1:0]                          src_done,
    output logic [NSRC-1:0]                          src_ready,
    input  logic [NSRC*DW-1:0]                       src_wdat,
    input  logic [NSRC*RW-1:0]                       src_reg_sel,
    input  logic                                     branch_spec,
    input  logic                                     branch_correct,
    input  logic                                     branch_mispredict,
    output logic                                     wen,
    output logic [RW-1:0]                            wsel,
    output logic [DW-1:0]                            wdat,
    output logic [((NSRC > 1) ? $clog2(NSRC) : 1)-1:0] wsrc,
    output logic                                     spec_pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;

    // FIFO storage and bookkeeping
    logic [DW-1:0]    dat_mem_r    [NSRC][DEPTH];
    logic [RW-1:0]    sel_mem_r    [NSRC][DEPTH];
    logic [DEPTH-1:0] spec_bits_r  [NSRC];
    logic [AW-1:0]    rptr_r       [NSRC];
    logic [AW-1:0]    wptr_r       [NSRC];
    logic [CW-1:0]    count_r      [NSRC];
    logic [CW-1:0]    spec_count_r [NSRC];

    // Per-source control for this cycle
    logic [NSRC-1:0]  accept_s;
    logic [NSRC-1:0]  head_elig_s;
    logic [NSRC-1:0]  byp_elig_s;
    logic [NSRC-1:0]  pop_s;
    logic [NSRC-1:0]  byp_s;
    logic [NSRC-1:0]  push_s;

    // Next-state values
    logic [AW-1:0]    base_wptr_s    [NSRC];
    logic [AW-1:0]    wptr_next_s    [NSRC];
    logic [AW-1:0]    rptr_next_s    [NSRC];
    logic [CW-1:0]    count_next_s   [NSRC];
    logic [CW-1:0]    spec_cnt_next_s[NSRC];
    logic [DEPTH-1:0] spec_next_s    [NSRC];

    // Winner of the fixed-priority selection
    logic             win_valid_s;
    logic [SW-1:0]    win_idx_s;
    logic [RW-1:0]    win_sel_s;
    logic [DW-1:0]    win_dat_s;

    // Mispredict overrides a simultaneous correct
    logic             squash_s;
    logic             commit_s;
    logic             clear_s;

    assign squash_s = branch_mispredict;
    assign commit_s = branch_correct & ~branch_mispredict;
    assign clear_s  = branch_correct | branch_mispredict;

    // Backpressure and speculation status straight from registered counts
    always_comb begin
        spec_pending = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            src_ready[i] = (count_r[i] != CW'(DEPTH));
            spec_pending = spec_pending | (spec_count_r[i] != {CW{1'b0}});
        end
    end

    // Eligibility on pre-update state, then lowest-index winner selection
    always_comb begin
        win_valid_s = 1'b0;
        win_idx_s   = {SW{1'b0}};
        win_sel_s   = {RW{1'b0}};
        win_dat_s   = {DW{1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            accept_s[i]    = src_done[i] & src_ready[i];
            head_elig_s[i] = (count_r[i] != {CW{1'b0}}) & ~spec_bits_r[i][rptr_r[i]];
            byp_elig_s[i]  = (count_r[i] == {CW{1'b0}}) & accept_s[i] & ~branch_spec;
            if (!win_valid_s && (head_elig_s[i] || byp_elig_s[i])) begin
                win_valid_s = 1'b1;
                win_idx_s   = SW'(i);
                pop_s[i]    = head_elig_s[i];
                byp_s[i]    = byp_elig_s[i];
                if (head_elig_s[i]) begin
                    win_sel_s = sel_mem_r[i][rptr_r[i]];
                    win_dat_s = dat_mem_r[i][rptr_r[i]];
                end else begin
                    win_sel_s = src_reg_sel[i*RW +: RW];
                    win_dat_s = src_wdat[i*DW +: DW];
                end
            end else begin
                pop_s[i] = 1'b0;
                byp_s[i] = 1'b0;
            end
            // A speculative input arriving with a mispredict is dropped
            push_s[i] = accept_s[i] & ~byp_s[i] & ~(branch_spec & squash_s);
        end
    end

    // Pointer, count and speculation-tag next state per source
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            base_wptr_s[i]  = squash_s ? (wptr_r[i] - spec_count_r[i][AW-1:0]) : wptr_r[i];
            wptr_next_s[i]  = base_wptr_s[i] + AW'(push_s[i]);
            rptr_next_s[i]  = rptr_r[i] + AW'(pop_s[i]);
            count_next_s[i] = count_r[i]
                            - (squash_s ? spec_count_r[i] : {CW{1'b0}})
                            + CW'(push_s[i])
                            - CW'(pop_s[i]);
            spec_cnt_next_s[i] = clear_s ? {CW{1'b0}}
                                         : (spec_count_r[i] + CW'(push_s[i] & branch_spec));
            for (int j = 0; j < DEPTH; j++) begin
                spec_next_s[i][j] = (push_s[i] && (base_wptr_s[i] == AW'(j)))
                                  ? (branch_spec & ~commit_s)
                                  : (clear_s ? 1'b0 : spec_bits_r[i][j]);
            end
        end
    end

    // FIFO bookkeeping registers; reset discards every buffered entry
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NSRC; i++) begin
                rptr_r[i]       <= {AW{1'b0}};
                wptr_r[i]       <= {AW{1'b0}};
                count_r[i]      <= {CW{1'b0}};
                spec_count_r[i] <= {CW{1'b0}};
                spec_bits_r[i]  <= {DEPTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                rptr_r[i]       <= rptr_next_s[i];
                wptr_r[i]       <= wptr_next_s[i];
                count_r[i]      <= count_next_s[i];
                spec_count_r[i] <= spec_cnt_next_s[i];
                spec_bits_r[i]  <= spec_next_s[i];
            end
        end
    end

    // FIFO payload storage; contents only matter below the valid count
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NSRC; i++) begin
            if (push_s[i]) begin
                dat_mem_r[i][base_wptr_s[i]] <= src_wdat[i*DW +: DW];
                sel_mem_r[i][base_wptr_s[i]] <= src_reg_sel[i*RW +: RW];
            end
        end
    end

    // Registered write port; writes to register 0 are consumed silently
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wen  <= 1'b0;
            wsel <= {RW{1'b0}};
            wdat <= {DW{1'b0}};
            wsrc <= {SW{1'b0}};
        end else if (win_valid_s) begin
            wen  <= (win_sel_s != {RW{1'b0}});
            wsel <= win_sel_s;
            wdat <= win_dat_s;
            wsrc <= win_idx_s;
        end else begin
            wen  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_spec_arbiter.sv
// Directed bench for wb_spec_arbiter: a table of single-cycle vectors plus
// hand-written sequences for fill/drain, mispredict and mid-run reset.

module tb_wb_spec_arbiter;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [2:0]  src_done = 3'b000;
    logic [2:0]  src_ready;
    logic [95:0] src_wdat = 96'd0;
    logic [14:0] src_reg_sel = 15'd0;
    logic        branch_spec = 1'b0;
    logic        branch_correct = 1'b0;
    logic        branch_mispredict = 1'b0;
    logic        wen;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic [1:0]  wsrc;
    logic        spec_pending;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic fade_seen = 1'b0;

    wb_spec_arbiter #(.NSRC(3), .DEPTH(8), .DW(32), .RW(5)) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .src_done         (src_done),
        .src_ready        (src_ready),
        .src_wdat         (src_wdat),
        .src_reg_sel      (src_reg_sel),
        .branch_spec      (branch_spec),
        .branch_correct   (branch_correct),
        .branch_mispredict(branch_mispredict),
        .wen              (wen),
        .wsel             (wsel),
        .wdat             (wdat),
        .wsrc             (wsrc),
        .spec_pending     (spec_pending)
    );

    always #5 CLK = ~CLK;

    // Squashed data must never reach the register file
    always @(negedge CLK) begin
        if (wen === 1'b1 && wdat === 32'hFADEFADE) fade_seen = 1'b1;
    end

    typedef struct {
        string       name;
        logic [2:0]  done;
        logic [4:0]  l_sel, j_sel, a_sel;
        logic [31:0] l_dat, j_dat, a_dat;
        logic        spec, cor, mis;
        logic        e_wen;
        logic [4:0]  e_sel;
        logic [31:0] e_dat;
        logic [1:0]  e_src;
        logic [2:0]  e_rdy;
        logic        e_pend;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input string nm, input logic [2:0] d,
                                input logic [4:0] ls, input logic [31:0] ld,
                                input logic [4:0] js, input logic [31:0] jd,
                                input logic [4:0] a_s, input logic [31:0] a_d,
                                input logic sp, input logic co, input logic mi,
                                input logic ew, input logic [4:0] es, input logic [31:0] ed,
                                input logic [1:0] esrc, input logic [2:0] er, input logic ep);
        vec_t v;
        v.name = nm; v.done = d;
        v.l_sel = ls; v.l_dat = ld; v.j_sel = js; v.j_dat = jd; v.a_sel = a_s; v.a_dat = a_d;
        v.spec = sp; v.cor = co; v.mis = mi;
        v.e_wen = ew; v.e_sel = es; v.e_dat = ed; v.e_src = esrc; v.e_rdy = er; v.e_pend = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] d,
                         input logic [4:0] ls, input logic [31:0] ld,
                         input logic [4:0] js, input logic [31:0] jd,
                         input logic [4:0] a_s, input logic [31:0] a_d,
                         input logic sp, input logic co, input logic mi);
        src_done          = d;
        src_reg_sel       = {a_s, js, ls};
        src_wdat          = {a_d, jd, ld};
        branch_spec       = sp;
        branch_correct    = co;
        branch_mispredict = mi;
    endtask

    task automatic idle();
        drive(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_wr(input string nm, input logic [4:0] s, input logic [31:0] d, input logic [1:0] src);
        chk({nm, ".wen"},  32'(wen),  32'd1);
        chk({nm, ".wsel"}, 32'(wsel), 32'(s));
        chk({nm, ".wdat"}, wdat, d);
        chk({nm, ".wsrc"}, 32'(wsrc), 32'(src));
    endtask

    initial begin
        // Single-cycle vectors: inputs applied, then outputs after the edge
        for (int i = 1; i <= 8; i++)
            vq.push_back(mk("alu_stream", 3'b100, 5'd0, 32'd0, 5'd0, 32'd0, 5'(i), 32'(i*1000),
                            1'b0, 1'b0, 1'b0, 1'b1, 5'(i), 32'(i*1000), 2'd2, 3'b111, 1'b0));
        vq.push_back(mk("alu_idle", 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0,
                        1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 3'b111, 1'b0));
        vq.push_back(mk("ld_alu_1", 3'b101, 5'd5, 32'd420, 5'd0, 32'd0, 5'd7, 32'd69,
                        1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'd420, 2'd0, 3'b111, 1'b0));
        vq.push_back(mk("ld_alu_2", 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0,
                        1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'd69, 2'd2, 3'b111, 1'b0));
        vq.push_back(mk("ld_alu_3", 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0,
                        1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 3'b111, 1'b0));
        vq.push_back(mk("tie_1", 3'b011, 5'd3, 32'hCAFEBABE, 5'd12, 32'hB00BB00B, 5'd0, 32'd0,
                        1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'hCAFEBABE, 2'd0, 3'b111, 1'b0));
        vq.push_back(mk("tie_2", 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0,
                        1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'hB00BB00B, 2'd1, 3'b111, 1'b0));
        vq.push_back(mk("tie_3", 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0,
                        1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 3'b111, 1'b0));
        vq.push_back(mk("reg0_1", 3'b100, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'h55,
                        1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 3'b111, 1'b0));
        vq.push_back(mk("reg0_2", 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0,
                        1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 3'b111, 1'b0));
        for (int i = 1; i <= 4; i++)
            vq.push_back(mk("spec_hold", 3'b100, 5'd0, 32'd0, 5'd0, 32'd0, 5'(i), 32'hDEADBEEF,
                            1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 3'b111, 1'b1));
        vq.push_back(mk("correct", 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0,
                        1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 3'b111, 1'b0));
        for (int i = 1; i <= 4; i++)
            vq.push_back(mk("commit_drain", 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0,
                            1'b0, 1'b0, 1'b0, 1'b1, 5'(i), 32'hDEADBEEF, 2'd2, 3'b111, 1'b0));
        vq.push_back(mk("commit_end", 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0,
                        1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 3'b111, 1'b0));

        // Reset state
        idle();
        #12;
        chk("rst.wen",  32'(wen),  32'd0);
        chk("rst.wsel", 32'(wsel), 32'd0);
        chk("rst.wdat", wdat,      32'd0);
        chk("rst.wsrc", 32'(wsrc), 32'd0);
        chk("rst.ready", 32'(src_ready), 32'd7);
        chk("rst.pend", 32'(spec_pending), 32'd0);
        nRST = 1'b1;

        // Table-driven vectors
        foreach (vq[k]) begin
            drive(vq[k].done, vq[k].l_sel, vq[k].l_dat, vq[k].j_sel, vq[k].j_dat,
                  vq[k].a_sel, vq[k].a_dat, vq[k].spec, vq[k].cor, vq[k].mis);
            step();
            chk($sformatf("%s[%0d].wen", vq[k].name, k), 32'(wen), 32'(vq[k].e_wen));
            if (vq[k].e_wen) begin
                chk($sformatf("%s[%0d].wsel", vq[k].name, k), 32'(wsel), 32'(vq[k].e_sel));
                chk($sformatf("%s[%0d].wdat", vq[k].name, k), wdat, vq[k].e_dat);
                chk($sformatf("%s[%0d].wsrc", vq[k].name, k), 32'(wsrc), 32'(vq[k].e_src));
            end
            chk($sformatf("%s[%0d].ready", vq[k].name, k), 32'(src_ready), 32'(vq[k].e_rdy));
            chk($sformatf("%s[%0d].pend", vq[k].name, k), 32'(spec_pending), 32'(vq[k].e_pend));
        end

        // Fill the alu FIFO behind a busy load stream, then drain it
        for (int c = 1; c <= 8; c++) begin
            drive(3'b101, 5'(20 + c), 32'(c), 5'd0, 32'd0, 5'(2*c), 32'(100*c), 1'b0, 1'b0, 1'b0);
            step();
            chk_wr($sformatf("fill[%0d]", c), 5'(20 + c), 32'(c), 2'd0);
            chk($sformatf("fill[%0d].ready2", c), 32'(src_ready[2]), (c < 8) ? 32'd1 : 32'd0);
        end
        drive(3'b101, 5'd29, 32'd9, 5'd0, 32'd0, 5'd18, 32'd900, 1'b0, 1'b0, 1'b0);
        step();
        chk_wr("fill[9]", 5'd29, 32'd9, 2'd0);
        chk("fill[9].ready2", 32'(src_ready[2]), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            drive((k <= 2) ? 3'b100 : 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd18, 32'd900,
                  1'b0, 1'b0, 1'b0);
            step();
            chk_wr($sformatf("drain[%0d]", k), 5'(2*k), 32'(100*k), 2'd2);
        end
        idle();
        step();
        chk("drain_end.wen", 32'(wen), 32'd0);
        chk("drain_end.ready", 32'(src_ready), 32'd7);

        // Non-spec entries buffered, spec entries queued behind, then squash
        for (int c = 1; c <= 3; c++) begin
            drive(3'b101, 5'(20 + c), 32'(c), 5'd0, 32'd0, 5'(c), 32'h0ADDADD0, 1'b0, 1'b0, 1'b0);
            step();
            chk_wr($sformatf("mis_buf[%0d]", c), 5'(20 + c), 32'(c), 2'd0);
        end
        for (int c = 4; c <= 7; c++) begin
            drive(3'b100, 5'd0, 32'd0, 5'd0, 32'd0, 5'(c), 32'hFADEFADE, 1'b1, 1'b0, 1'b0);
            step();
            if (c <= 6) chk_wr($sformatf("mis_spec[%0d]", c), 5'(c - 3), 32'h0ADDADD0, 2'd2);
            else chk("mis_spec[7].wen", 32'(wen), 32'd0);
            chk($sformatf("mis_spec[%0d].pend", c), 32'(spec_pending), 32'd1);
        end
        drive(3'b100, 5'd0, 32'd0, 5'd0, 32'd0, 5'd8, 32'hFADEFADE, 1'b1, 1'b0, 1'b1);
        step();
        chk("mispredict.wen", 32'(wen), 32'd0);
        chk("mispredict.pend", 32'(spec_pending), 32'd0);
        drive(3'b101, 5'd21, 32'd1, 5'd0, 32'd0, 5'd9, 32'h12345678, 1'b0, 1'b0, 1'b0);
        step();
        chk_wr("post_mis[0]", 5'd21, 32'd1, 2'd0);
        idle();
        step();
        chk_wr("post_mis[1]", 5'd9, 32'h12345678, 2'd2);
        step();
        chk("post_mis[2].wen", 32'(wen), 32'd0);
        chk("post_mis[2].ready", 32'(src_ready), 32'd7);

        // Fill jump and alu FIFOs, then reset asynchronously mid-cycle
        for (int c = 1; c <= 8; c++) begin
            drive(3'b111, 5'(20 + c), 32'(c), 5'd1, 32'(256 + c), 5'd2, 32'(512 + c),
                  1'b0, 1'b0, 1'b0);
            step();
        end
        chk("full.ready", 32'(src_ready), 32'd1);
        chk("full.wen", 32'(wen), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("midrst.wen",   32'(wen),  32'd0);
        chk("midrst.wsel",  32'(wsel), 32'd0);
        chk("midrst.wdat",  wdat,      32'd0);
        chk("midrst.wsrc",  32'(wsrc), 32'd0);
        chk("midrst.ready", 32'(src_ready), 32'd7);
        chk("midrst.pend",  32'(spec_pending), 32'd0);
        idle();
        nRST = 1'b1;
        step();
        chk("after_rst.wen", 32'(wen), 32'd0);
        chk("after_rst.ready", 32'(src_ready), 32'd7);

        chk("no_fadefade_write", 32'(fade_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
